// File: rtl/rptr_level_if.sv
// Read-side status bus for the gray-code async FIFO read pointer block.
//  slave  : the rptr_level block (consumes pop/threshold, produces pointers/status)
//  master : the read-side consumer driving pops and observing status
// Signals:
//  rinc, rq2_wptr, ae_thresh, uf_clr                        master -> slave
//  raddr, rptr, rempty, ralmostempty, rlevel, runderflow,
//  ruf_cnt                                                  slave -> master
interface rptr_level_if #(
    parameter int ADDRSIZE = 4,
    parameter int UFCNT_W  = 8
);
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE:0]   ae_thresh;
    logic                uf_clr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                ralmostempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;
    logic [UFCNT_W-1:0]  ruf_cnt;

    modport slave (
        input  rinc, rq2_wptr, ae_thresh, uf_clr,
        output raddr, rptr, rempty, ralmostempty, rlevel, runderflow, ruf_cnt
    );

    modport master (
        output rinc, rq2_wptr, ae_thresh, uf_clr,
        input  raddr, rptr, rempty, ralmostempty, rlevel, runderflow, ruf_cnt
    );
endinterface

// File: rtl/rptr_level.sv
// Read-side pointer/status block for the gray-code async FIFO, rclk domain.
// Produces the binary RAM read address and the registered gray read pointer
// (to the wclk synchroniser), and derives empty, almost-empty, occupancy and
// underflow status from the write pointer already synchronised into rclk.
// Ports:
//  rclk  - read clock
//  rrst  - asynchronous active-high reset
//  bus   - rptr_level_if.slave: rinc, rq2_wptr, ae_thresh, uf_clr in;
//          raddr, rptr, rempty, ralmostempty, rlevel, runderflow, ruf_cnt out
module rptr_level #(
    parameter int ADDRSIZE = 4,
    parameter int UFCNT_W  = 8
) (
    input  logic         rclk,
    input  logic         rrst,
    rptr_level_if.slave  bus
);

    logic [ADDRSIZE:0]  rbin;
    logic [ADDRSIZE:0]  rptr_q;
    logic               rempty_q;
    logic               ralmostempty_q;
    logic [ADDRSIZE:0]  rlevel_q;
    logic               runderflow_q;
    logic [UFCNT_W-1:0] ruf_cnt_q;

    logic               pop;
    logic               uf_evt;
    logic [ADDRSIZE:0]  rbinnext;
    logic [ADDRSIZE:0]  rgraynext;
    logic [ADDRSIZE:0]  wbin;
    logic [ADDRSIZE:0]  lvl_next;
    logic               empty_next;

    // A pop against an empty FIFO is dropped; it only counts as underflow.
    assign pop       = bus.rinc & ~rempty_q;
    assign uf_evt    = bus.rinc & rempty_q;
    assign rbinnext  = rbin + (ADDRSIZE+1)'(pop);
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(bus.rq2_wptr >> i);
        end
    end

    // Modulo subtraction keeps occupancy correct across the pointer wrap.
    assign lvl_next   = wbin - rbinnext;
    assign empty_next = (rgraynext == bus.rq2_wptr);

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin           <= '0;
            rptr_q         <= '0;
            rempty_q       <= 1'b1;
            ralmostempty_q <= 1'b1;
            rlevel_q       <= '0;
            runderflow_q   <= 1'b0;
            ruf_cnt_q      <= '0;
        end else begin
            rbin           <= rbinnext;
            rptr_q         <= rgraynext;
            rempty_q       <= empty_next;
            rlevel_q       <= lvl_next;
            ralmostempty_q <= (lvl_next <= bus.ae_thresh) | empty_next;
            runderflow_q   <= uf_evt;
            if (bus.uf_clr) begin
                ruf_cnt_q <= '0;
            end else if (uf_evt && !(&ruf_cnt_q)) begin
                ruf_cnt_q <= ruf_cnt_q + UFCNT_W'(1);
            end
        end
    end

    assign bus.raddr        = rbin[ADDRSIZE-1:0];
    assign bus.rptr         = rptr_q;
    assign bus.rempty       = rempty_q;
    assign bus.ralmostempty = ralmostempty_q;
    assign bus.rlevel       = rlevel_q;
    assign bus.runderflow   = runderflow_q;
    assign bus.ruf_cnt      = ruf_cnt_q;

endmodule
